irq_controller: RTL

Parametrised interrupt controller sitting between external interrupt lines and the `csr` unit of the 5-stage pipeline, replacing the single `e_interrupt` input with NUM_SRC prioritised sources. It synchronises and latches sources, arbitrates by programmable priority against a threshold, raises one request towards the CSR trap logic, and tracks the serviced source through a claim/complete handshake tied to trap entry and `mret`. Its registers are accessed over the same `reg_wr`/`reg_rd`/`addr`/`wdata`/`rdata` style bus as the CSR file.

---
 rtl/irq_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// ============================================================================
// Module   : irq_controller
// Purpose  : Prioritised interrupt controller feeding the CSR trap logic, with a
//            claim/complete handshake. Optional macro IRQ_EDGE_EN turns on
//            per-source edge detection selected by EDGE_MASK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller #(
  parameter int unsigned          NUM_SRC   = 8,
  parameter int unsigned          PRIO_W    = 3,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = '0,
  parameter int unsigned          ID_W      = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [7:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic               claim,
  input  logic               complete,
  input  logic [ID_W-1:0]    complete_id,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [ID_W-1:0]    svc_id,
  output logic               err
);

  localparam logic [7:0] ADDR_ENABLE    = 8'h00;
  localparam logic [7:0] ADDR_PENDING   = 8'h01;
  localparam logic [7:0] ADDR_THRESHOLD = 8'h02;
  localparam logic [7:0] ADDR_STATUS    = 8'h03;
  localparam int         PRIO_BASE      = 16;

  // Sources flagged here latch rising edges; all others track their level.
`ifdef IRQ_EDGE_EN
  localparam logic [NUM_SRC-1:0] EDGE_SEL = EDGE_MASK;
`else
  localparam logic [NUM_SRC-1:0] EDGE_SEL = EDGE_MASK & '0;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  sync1_q, sync1_d;
  logic [NUM_SRC-1:0]  sync2_q, sync2_d;
  logic [NUM_SRC-1:0]  sync3_q, sync3_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0]   threshold_q, threshold_d;
  logic [PRIO_W-1:0]   prio_q [NUM_SRC];
  logic [PRIO_W-1:0]   prio_d [NUM_SRC];
  logic                best_valid_q, best_valid_d;
  logic [ID_W-1:0]     best_id_q, best_id_d;
  logic [ID_W-1:0]     svc_id_q, svc_id_d;
  logic                err_q, err_d;

  logic [NUM_SRC-1:0]  cand;
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  clr;
  logic [PRIO_W-1:0]   best_prio;
  logic                claim_take;
  logic                unused_wdata;

  assign unused_wdata = ^wdata;

  // Completion has precedence: a claim in the same cycle is dropped.
  assign claim_take = claim && !complete && (state_q == S_IDLE) && best_valid_q;

  always_comb begin
    sync1_d = irq_src;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise    = sync2_q & ~sync3_q;
    clr     = '0;
    if (reg_wr && addr == ADDR_PENDING) clr = wdata[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim_take && best_id_q == ID_W'(i + 1)) clr[i] = 1'b1;
    end
    // Set beats clear on edge sources.
    pending_d = (EDGE_SEL & ((pending_q & ~clr) | rise)) | (~EDGE_SEL & sync2_q);
  end

  always_comb begin
    enable_d    = enable_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    if (reg_wr) begin
      case (addr)
        ADDR_ENABLE:    enable_d    = wdata[NUM_SRC-1:0];
        ADDR_THRESHOLD: threshold_d = wdata[PRIO_W-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_SRC; i++) begin
        if (addr == 8'(PRIO_BASE + i)) prio_d[i] = wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    cand         = pending_q & enable_q;
    best_valid_d = 1'b0;
    best_id_d    = '0;
    best_prio    = '0;
    // Strict '>' keeps the lowest index on equal priority.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && (prio_q[i] > threshold_q) &&
          (!best_valid_d || prio_q[i] > best_prio)) begin
        best_valid_d = 1'b1;
        best_prio    = prio_q[i];
        best_id_d    = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    svc_id_d = svc_id_q;
    err_d    = err_q;
    if (reg_wr && addr == ADDR_STATUS) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (complete) begin
          err_d = 1'b1;
        end else if (claim_take) begin
          svc_id_d = best_id_q;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (complete) begin
          if (complete_id == svc_id_q) begin
            svc_id_d = '0;
            state_d  = S_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      threshold_q  <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      svc_id_q     <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      svc_id_q     <= svc_id_d;
      err_q        <= err_d;
      prio_q       <= prio_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (reg_rd) begin
      case (addr)
        ADDR_ENABLE:    rdata[NUM_SRC-1:0] = enable_q;
        ADDR_PENDING:   rdata[NUM_SRC-1:0] = pending_q;
        ADDR_THRESHOLD: rdata[PRIO_W-1:0]  = threshold_q;
        ADDR_STATUS: begin
          rdata[ID_W-1:0] = svc_id_q;
          rdata[31]       = err_q;
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_SRC; i++) begin
        if (addr == 8'(PRIO_BASE + i)) rdata[PRIO_W-1:0] = prio_q[i];
      end
    end
  end

  assign irq_req = (state_q == S_IDLE) && best_valid_q;
  assign irq_id  = irq_req ? best_id_q : '0;
  assign svc_id  = svc_id_q;
  assign err     = err_q;

endmodule

`default_nettype wire
